// File: rtl/riscv_fetch_queue.sv
// Instruction fetch unit: in-order request issue, response queue, redirect flush.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module riscv_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = AW + 2;
    localparam logic [SW-1:0] LP_DEPTH = SW'(DEPTH);
    localparam logic [31:0] LP_RESET_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pcq  [DEPTH];

    logic [31:0]   w_redir_pc;
    logic [SW-1:0] w_sum_oc;
    logic [SW-1:0] w_sum_od;
    logic [SW-1:0] w_pend;
    logic          w_req_fire;
    logic          w_rsp_take;
    logic          w_rsp_drop;
    logic          w_pop;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_disc_nxt;

    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_sum_oc   = {1'b0, r_out} + {1'b0, r_count};
    assign w_sum_od   = {1'b0, r_out} + {1'b0, r_disc};

    // Both bounds keep queue space for every live request and cap pending responses.
    assign imem_req_valid = !rst && !redirect_valid
                          && (w_sum_oc < LP_DEPTH)
                          && (w_sum_od < LP_DEPTH);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_take = imem_rsp_valid && !redirect_valid && (r_disc == '0);
    assign w_rsp_drop = imem_rsp_valid && !redirect_valid && (r_disc != '0);

    assign inst_valid = (r_count != '0) && !redirect_valid;
    assign inst_data  = r_data[r_head];
    assign inst_pc    = r_pcq[r_head];
    assign w_pop      = inst_valid && inst_ready;

    always_comb begin
        w_out_nxt  = r_out;
        w_disc_nxt = r_disc;
        w_pend     = {1'b0, r_disc} + {1'b0, r_out};
        if (redirect_valid) begin
            // Everything still in flight becomes garbage to skip.
            if (imem_rsp_valid && (w_pend != '0)) begin
                w_pend = w_pend - 1'b1;
            end
            w_out_nxt  = '0;
            w_disc_nxt = w_pend[CW-1:0];
        end else begin
            w_out_nxt = r_out + CW'(w_req_fire) - CW'(w_rsp_take);
            if (w_rsp_drop) begin
                w_disc_nxt = r_disc - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= LP_RESET_PC;
            r_rsp_pc <= LP_RESET_PC;
            r_out    <= '0;
            r_disc   <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pcq[i]  <= '0;
            end
        end else begin
            r_out  <= w_out_nxt;
            r_disc <= w_disc_nxt;
            if (redirect_valid) begin
                r_pc     <= w_redir_pc;
                r_rsp_pc <= w_redir_pc;
                r_head   <= '0;
                r_tail   <= '0;
                r_count  <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                // Responses are in order, so the next kept one maps to r_rsp_pc.
                if (w_rsp_take) begin
                    r_data[r_tail] <= imem_rsp_data;
                    r_pcq[r_tail]  <= r_rsp_pc;
                    r_tail         <= r_tail + 1'b1;
                    r_rsp_pc       <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + CW'(w_rsp_take) - CW'(w_pop);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (inst_ready && !inst_valid) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/riscv_fetch_queue.md
RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries and maximum outstanding requests; power of 2, 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  in-order response returned this cycle.
REQ-009 imem_rsp_data  input  32  instruction word of the response.
REQ-010 redirect_valid  input  1  branch/jump taken by the core; flush.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-012 inst_valid  output  1  queue head holds an instruction for the core.
REQ-013 inst_ready  input  1  core consumes head this cycle.
REQ-014 inst_data  output  32  head instruction word.
REQ-015 inst_pc  output  32  head instruction address.

Function
REQ-016 Request handshake SHALL occur when imem_req_valid and imem_req_ready are both 1; fetch pc then advances by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 imem_req_valid SHALL be 1 only when outstanding + occupancy < DEPTH and redirect_valid = 0.
REQ-018 imem_req_valid, once asserted, SHALL hold with stable imem_req_addr until accepted, unless redirect_valid is 1.
REQ-019 Each non-discarded response SHALL be written with its request pc at the tail; inst_valid SHALL rise the cycle after (no bypass; minimum 2 cycles from request accept to inst_valid).
REQ-020 Response arriving when queue is full SHALL be impossible by REQ-017; the design SHALL NOT drop it.
REQ-021 Consume handshake (inst_valid and inst_ready) SHALL pop the head; a pop and a write in the same cycle SHALL both take effect, occupancy unchanged.
REQ-022 In a redirect_valid cycle: inst_valid SHALL be forced 0, imem_req_valid forced 0, any imem_rsp_valid dropped.
REQ-023 On the edge ending a redirect cycle: queue emptied, fetch pc = redirect_pc, discard counter = outstanding minus any response arriving that cycle, outstanding = 0.
REQ-024 While discard counter > 0, each response SHALL decrement it and SHALL NOT be written.
REQ-025 Outstanding plus discard counter SHALL never exceed DEPTH; new requests after redirect are allowed while discards are pending.
REQ-026 Back-to-back redirects SHALL each apply; last one wins; discard counter accumulates.
REQ-027 With imem_req_ready and imem_rsp_valid held 1 with 1-cycle latency and inst_ready 1, throughput SHALL be one instruction per cycle.

Reset
REQ-028 While rst = 1: fetch pc = RESET_PC, queue empty, outstanding = 0, discard = 0, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-029 Reset mid-operation SHALL abandon all in-flight requests; responses returned after rst deasserts SHALL be the environment's responsibility (memory reset together).
REQ-030 First imem_req_valid = 1 SHALL occur in the first cycle after rst deasserts.

Configuration
REQ-031 Macro FETCH_PERF_EN, when defined, SHALL add outputs perf_stall_cnt (32, cycles with inst_ready = 1 and inst_valid = 0) and perf_flush_cnt (32, redirect cycles), both reset to 0 and wrapping.
REQ-032 Without FETCH_PERF_EN those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset then ready/rsp 1-cycle latency, inst_ready = 1 -> addrs 0x0,0x4,0x8; inst_valid first at cycle 3; inst_pc 0x0,0x4,0x8 consecutive cycles.
REQ-034 inst_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, imem_req_valid then 0; inst_ready = 1 one cycle -> one new request issued.
REQ-035 Two requests outstanding, redirect_pc = 0x100 -> both responses dropped, next inst_pc = 0x100, no stale pc delivered.
REQ-036 Redirect in same cycle as response and pop -> response dropped, no pop, queue empty next cycle, discard = outstanding-1.
REQ-037 Fetch pc 0xFFFF_FFFC accepted -> next imem_req_addr 0x0000_0000.
REQ-038 With FETCH_PERF_EN: 3 redirects and 5 empty-queue ready cycles -> perf_flush_cnt = 3, perf_stall_cnt = 5.
